// File: rtl/uart_tx_feeder.sv
// Buffered transmit front-end: queues host bytes in a FIFO and launches them one at a
// time into a UART transmitter, waiting for each tx_done before starting the next.
module uart_tx_feeder #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    input  logic                  flush,
    input  logic                  tx_en,
    output logic [DATA_WIDTH-1:0] tx_data,
    output logic                  start_tx,
    input  logic                  tx_done,
    output logic [AW:0]           count,
    output logic                  empty,
    output logic                  full,
    output logic                  busy
);

    // Handshakes: a host write transfers on a clock edge where wr_valid && wr_ready;
    // wr_ready reflects only the registered count, so a same-cycle pop never raises it.
    // Towards the UART, start_tx is a one-cycle launch with tx_data valid, and the
    // character is owned by the UART until its one-cycle tx_done pulse.

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    state_e                state_q, state_d;
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [AW:0]           count_q, count_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  start_tx_q, start_tx_d;
    logic                  busy_q, busy_d;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  do_write;
    logic                  do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign wr_ready = !full;
    assign count    = count_q;
    assign tx_data  = tx_data_q;
    assign start_tx = start_tx_q;
    assign busy     = busy_q;

    assign do_write = wr_valid && !full && !flush;
    assign do_pop   = (state_q == S_IDLE) && !empty && tx_en && !flush;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_write) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)   rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_write && !do_pop)      count_d = count_q + (AW+1)'(1);
            else if (!do_write && do_pop) count_d = count_q - (AW+1)'(1);
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_data_d  = tx_data_q;
        start_tx_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (do_pop) begin
                    tx_data_d  = mem[rd_ptr_q];
                    start_tx_d = 1'b1;
                    state_d    = S_START;
                end
            end
            S_START: state_d = S_WAIT;
            S_WAIT: begin
                if (tx_done) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            tx_data_q  <= '0;
            start_tx_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            tx_data_q  <= tx_data_d;
            start_tx_q <= start_tx_d;
            busy_q     <= busy_d;
        end
    end

    // Storage is not reset; only the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (reset_n && do_write) mem[wr_ptr_q] <= wr_data;
    end

endmodule
